// File: rtl/branch_predictor_if.sv
// ============================================================================
// Module      : branch_predictor_if
// Description : Lookup/update/statistics bundle between pipeline and predictor.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface branch_predictor_if #(
    parameter int PC_WIDTH  = 64,
    parameter int CNT_WIDTH = 32
);
    logic [PC_WIDTH-1:0]  fetch_pc;
    logic                 prediction;
    logic                 update_valid;
    logic [PC_WIDTH-1:0]  update_pc;
    logic                 branchtaken;
    logic                 update_prediction;
    logic                 mispredict;
    logic [CNT_WIDTH-1:0] branch_count;
    logic [CNT_WIDTH-1:0] mispredict_count;

    modport master (
        output fetch_pc,
        output update_valid,
        output update_pc,
        output branchtaken,
        output update_prediction,
        input  prediction,
        input  mispredict,
        input  branch_count,
        input  mispredict_count
    );

    modport slave (
        input  fetch_pc,
        input  update_valid,
        input  update_pc,
        input  branchtaken,
        input  update_prediction,
        output prediction,
        output mispredict,
        output branch_count,
        output mispredict_count
    );
endinterface

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BHT of 2-bit saturating counters with
//               registered mispredict flag and saturating statistics.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module branch_predictor #(
    parameter int PC_WIDTH   = 64,
    parameter int INDEX_BITS = 6,
    parameter int CNT_WIDTH  = 32
) (
    input  wire               clk,
    input  wire               rst,
    branch_predictor_if.slave bp
);
    localparam int         ENTRIES   = 1 << INDEX_BITS;
    localparam logic [1:0] C_WEAK_NT = 2'b01;
    localparam logic [1:0] C_STRONG_T  = 2'b11;
    localparam logic [1:0] C_STRONG_NT = 2'b00;

    logic [1:0]            bht_q [ENTRIES];
    logic [1:0]            bht_d;
    logic [INDEX_BITS-1:0] fetch_idx;
    logic [INDEX_BITS-1:0] upd_idx;
    logic                  mispredict_q;
    logic                  mispredict_d;
    logic [CNT_WIDTH-1:0]  branch_count_q;
    logic [CNT_WIDTH-1:0]  branch_count_d;
    logic [CNT_WIDTH-1:0]  mispredict_count_q;
    logic [CNT_WIDTH-1:0]  mispredict_count_d;

    assign fetch_idx = bp.fetch_pc[INDEX_BITS+1:2];
    assign upd_idx   = bp.update_pc[INDEX_BITS+1:2];

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign bp.prediction       = bht_q[fetch_idx][1];
    assign bp.mispredict       = mispredict_q;
    assign bp.branch_count     = branch_count_q;
    assign bp.mispredict_count = mispredict_count_q;

    always_comb begin
        bht_d              = C_WEAK_NT;
        mispredict_d       = 1'b0;
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (bp.update_valid) begin
            bht_d = bht_q[upd_idx];
            if (bp.branchtaken) begin
                if (bht_d != C_STRONG_T) bht_d = bht_d + 2'b01;
            end else begin
                if (bht_d != C_STRONG_NT) bht_d = bht_d - 2'b01;
            end
            mispredict_d = (bp.branchtaken != bp.update_prediction);
            if (branch_count_q != {CNT_WIDTH{1'b1}})
                branch_count_d = branch_count_q + CNT_WIDTH'(1);
            if (mispredict_d && (mispredict_count_q != {CNT_WIDTH{1'b1}}))
                mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) bht_q[i] <= C_WEAK_NT;
            mispredict_q       <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (bp.update_valid) bht_q[upd_idx] <= bht_d;
            mispredict_q       <= mispredict_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed plus randomized checks against a table-of-integers model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_branch_predictor;
    localparam int PC_WIDTH   = 64;
    localparam int INDEX_BITS = 6;
    localparam int CNT_WIDTH  = 4;
    localparam int ENTRIES    = 1 << INDEX_BITS;
    localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    branch_predictor_if #(.PC_WIDTH(PC_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bpif ();

    branch_predictor #(
        .PC_WIDTH  (PC_WIDTH),
        .INDEX_BITS(INDEX_BITS),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bp (bpif.slave)
    );

    int m_bht [ENTRIES];
    int m_bcnt;
    int m_mcnt;
    int m_misp;
    int n_checks = 0;
    int n_pass   = 0;

    function automatic int idx_of(input logic [63:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic int m_pred(input logic [63:0] pc);
        return (m_bht[idx_of(pc)] >= 2) ? 1 : 0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_bht[i] = 1;
        m_bcnt = 0;
        m_mcnt = 0;
        m_misp = 0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".mispredict"}, 64'(bpif.mispredict), 64'(m_misp));
        check({tag, ".branch_count"}, 64'(bpif.branch_count), 64'(m_bcnt));
        check({tag, ".mispredict_count"}, 64'(bpif.mispredict_count), 64'(m_mcnt));
    endtask

    // Combinational lookup check, performed mid-cycle.
    task automatic look(input string tag, input logic [63:0] pc);
        bpif.fetch_pc = pc;
        #1;
        check(tag, 64'(bpif.prediction), 64'(m_pred(pc)));
    endtask

    task automatic cycle(input string tag, input logic uv, input logic [63:0] upc,
                         input logic bt, input logic up, input logic [63:0] fpc);
        int i;
        bpif.update_valid      = uv;
        bpif.update_pc         = uv ? upc : 'x;
        bpif.branchtaken       = bt;
        bpif.update_prediction = up;
        look({tag, ".pred"}, fpc);
        @(posedge clk);
        if (uv) begin
            i = idx_of(upc);
            m_bht[i] = bt ? ((m_bht[i] < 3) ? m_bht[i] + 1 : 3) : ((m_bht[i] > 0) ? m_bht[i] - 1 : 0);
            m_misp = (bt != up) ? 1 : 0;
            if (m_bcnt < CNT_MAX) m_bcnt++;
            if (m_misp == 1 && m_mcnt < CNT_MAX) m_mcnt++;
        end else begin
            m_misp = 0;
        end
        #1;
        bpif.update_valid = 1'b0;
        bpif.update_pc    = 'x;
        check_regs(tag);
    endtask

    task automatic do_reset(input logic uv, input logic [63:0] upc);
        bpif.update_valid      = uv;
        bpif.update_pc         = upc;
        bpif.branchtaken       = 1'b1;
        bpif.update_prediction = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bpif.update_valid = 1'b0;
        model_reset();
    endtask

    task automatic train(input logic [63:0] pc, input logic bt);
        cycle("train", 1'b1, pc, bt, 1'(m_pred(pc)), pc);
    endtask

    initial begin
        bpif.fetch_pc          = '0;
        bpif.update_valid      = 1'b0;
        bpif.update_pc         = 'x;
        bpif.branchtaken       = 1'b0;
        bpif.update_prediction = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset then sweep every index.
        do_reset(1'b0, '0);
        check_regs("reset");
        for (int a = 0; a <= 'hFC; a += 4) look("reset_sweep", 64'(a));

        // Single training step.
        cycle("single", 1'b1, 64'h40, 1'b1, 1'b0, 64'h40);
        look("single_0x40", 64'h40);
        look("single_0x44", 64'h44);

        // Saturation and hysteresis.
        for (int k = 0; k < 5; k++) train(64'h40, 1'b1);
        train(64'h40, 1'b0);
        look("hyst_nt1", 64'h40);
        train(64'h40, 1'b0);
        look("hyst_nt2", 64'h40);
        for (int k = 0; k < 3; k++) train(64'h40, 1'b0);
        train(64'h40, 1'b1);
        look("hyst_t_from_00", 64'h40);

        // Aliasing and same-cycle update/lookup.
        do_reset(1'b0, '0);
        for (int k = 0; k < 3; k++) train(64'h40, 1'b1);
        look("alias_0x140", 64'h140);
        cycle("same_cycle", 1'b1, 64'h40, 1'b0, 1'b1, 64'h40);
        look("same_cycle_after", 64'h40);

        // Reset mid-operation with a concurrent update.
        for (int k = 0; k < 3; k++) begin
            train(64'h80, 1'b1);
            train(64'h1C, 1'b1);
        end
        look("mid_pre_0x80", 64'h80);
        do_reset(1'b1, 64'h80);
        check_regs("mid_reset");
        for (int a = 0; a <= 'hFC; a += 4) look("mid_sweep", 64'(a));

        // Statistics saturation.
        for (int k = 0; k < 20; k++) begin
            logic t;
            t = 1'($urandom_range(0, 1));
            cycle("stat_sat", 1'b1, 64'(k * 4), t, ~t, 64'h0);
        end
        cycle("stat_correct", 1'b1, 64'h8, 1'b1, 1'b1, 64'h8);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            logic [63:0] upc, fpc;
            upc = {$urandom, $urandom};
            fpc = ($urandom_range(0, 1) == 1) ? upc : {$urandom, $urandom};
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1'($urandom_range(0, 1)), upc);
                check_regs("rand_reset");
            end else begin
                cycle("rand", 1'($urandom_range(0, 3) != 0), upc,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fpc);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor producing the `prediction` input consumed by the control unit in ID.
- Consumes the resolved `branchtaken` outcome to train itself.
- Direct-mapped branch history table (BHT) of 2-bit saturating counters, indexed by PC. Looked up at fetch, updated at branch resolution.
- Also reports registered per-branch mispredict status and saturating performance counters.

Parameters:
- PC_WIDTH, 64, width of fetch/update program counters
- INDEX_BITS, 6, log2 of BHT entries; index = pc[INDEX_BITS+1:2]
- CNT_WIDTH, 32, width of the statistics counters

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- fetch_pc  in  PC_WIDTH  PC of instruction in IF
- prediction  out  1  predicted direction for fetch_pc (1 = taken)
- update_valid  in  1  a conditional branch resolves this cycle
- update_pc  in  PC_WIDTH  PC of the resolving branch
- branchtaken  in  1  resolved outcome of the branch (1 = taken)
- update_prediction  in  1  prediction originally issued for this branch, carried down the pipeline
- mispredict  out  1  registered: previous-cycle update was mispredicted
- branch_count  out  CNT_WIDTH  resolved branches since reset, saturating
- mispredict_count  out  CNT_WIDTH  mispredicted branches since reset, saturating

Behaviour:
- **Clock and reset:** one clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- **Reset:**
  - All 2^INDEX_BITS BHT entries = 2'b01 (weakly not-taken).
  - mispredict = 0, branch_count = 0, mispredict_count = 0.
  - prediction therefore = 0 for every fetch_pc from the first cycle after reset.
  - rst overrides any concurrent update; reset mid-run discards all training.
- **Lookup:**
  - prediction = bht[fetch_pc[INDEX_BITS+1:2]][1].
  - Combinational read of registered state, zero-cycle latency.
  - Bits of fetch_pc outside the index are ignored, so aliasing is permitted.
- **Update (update_valid=1 at clock edge), idx_u = update_pc[INDEX_BITS+1:2]:**
  - branchtaken=1: bht[idx_u] increments, saturating at 2'b11.
  - branchtaken=0: bht[idx_u] decrements, saturating at 2'b00.
  - New value visible to lookup from the next cycle.
- **Counter state meaning:**
  - 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
  - prediction = MSB.
- **Same-cycle update and lookup to the same index:** prediction reflects the pre-update value. No bypass.
- **update_valid=0:** BHT unchanged, mispredict <= 0, counters hold.
- **mispredict:** mispredict <= update_valid & (branchtaken != update_prediction). Valid exactly one cycle after the update edge.
- **branch_count:** increments by 1 per update_valid cycle. Holds at all-ones when saturated.
- **mispredict_count:** increments on the same condition as mispredict. Holds at all-ones when saturated.
- **Unknown inputs:** no X propagation from update_pc when update_valid=0. The table is written only on update_valid.
- **Scope:** no pipeline stalls handled internally. The caller holds update_valid low for bubbles and flushed branches.

Test Plan:
- **Reset then lookup:** rst=1 for one cycle, sweep fetch_pc 0x0..0xFC -> prediction=0 everywhere; mispredict=0, both counts 0.
- **Single training:** update_valid=1, update_pc=0x40, branchtaken=1, update_prediction=0 -> next cycle prediction(0x40)=1, mispredict=1, branch_count=1, mispredict_count=1; prediction(0x44)=0.
- **Saturation/hysteresis:** 5 taken updates at 0x40 (entry 11), then 1 not-taken -> prediction still 1; 2nd not-taken -> 0; 3 more not-taken -> entry 00, one taken -> prediction still 0.
- **Aliasing and same-cycle hazard:**
  - Train 0x40 to 11 -> prediction(0x140)=1 (same index 16).
  - With fetch_pc=0x40 and a not-taken update to 0x40 in the same cycle -> prediction=1 that cycle, and 1 after (entry 10).
- **Reset mid-operation:** train several entries to 11 with counts nonzero, assert rst one cycle while update_valid=1 -> all predictions 0, counts 0, mispredict 0; the concurrent update is discarded.
- **Stats saturation (CNT_WIDTH=4):** 20 mispredicted updates -> branch_count=15, mispredict_count=15, held; a correct prediction keeps mispredict=0 next cycle.
